// File: rtl/truth_table_checker.sv
// truth_table_checker: captures the 8-entry truth table of a 3-input stage from sampled vectors
// and compares it against EXPECTED, reporting pass, mismatch locations, conflicts and timeout.
module truth_table_checker #(
    parameter logic [7:0] EXPECTED = 8'hE8,
    parameter int         TIMEOUT  = 64,
    parameter int         TW       = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       valid,
    input  logic       p1,
    input  logic       p2,
    input  logic       p3,
    input  logic       res,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [7:0] mismatch,
    output logic [3:0] err_cnt,
    output logic       conflict,
    output logic       timeout
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] COMPARE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]    state;
    logic [7:0]    seen;
    logic [7:0]    seen_nxt;
    logic [7:0]    diff;
    logic [3:0]    ones;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic          expire;

    assign idx    = {p1, p2, p3};
    assign expire = timer == TW'(TIMEOUT - 1);
    assign busy   = state == COLLECT || state == COMPARE;
    assign done   = state == DONE;

    // completion looks at the mask including this cycle's sample, so it beats timer expiry
    always_comb begin
        seen_nxt = valid ? seen | (8'b1 << idx) : seen;
        diff     = (table_out ^ EXPECTED) & seen;
        ones     = '0;
        for (int i = 0; i < 8; i++) ones = ones + 4'(diff[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seen      <= '0;
            timer     <= '0;
            pass      <= 1'b0;
            table_out <= '0;
            mismatch  <= '0;
            err_cnt   <= '0;
            conflict  <= 1'b0;
            timeout   <= 1'b0;
        end else if (start && (state == IDLE || state == DONE)) begin
            state     <= COLLECT;
            seen      <= '0;
            timer     <= '0;
            pass      <= 1'b0;
            table_out <= '0;
            mismatch  <= '0;
            err_cnt   <= '0;
            conflict  <= 1'b0;
            timeout   <= 1'b0;
        end else if (state == COLLECT) begin
            timer <= timer + 1'b1;
            if (valid && !seen[idx]) begin
                table_out[idx] <= res;
                seen[idx]      <= 1'b1;
            end else if (valid && res != table_out[idx]) begin
                conflict <= 1'b1;
            end
            if (seen_nxt == 8'hFF) begin
                state <= COMPARE;
            end else if (expire) begin
                state   <= COMPARE;
                timeout <= 1'b1;
            end
        end else if (state == COMPARE) begin
            mismatch <= diff;
            err_cnt  <= ones;
            pass     <= diff == '0 && seen == 8'hFF && !conflict && !timeout;
            state    <= DONE;
        end
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed and random runs checked against a sample-list reference model.
module tb_truth_table_checker;
    localparam logic [7:0] EXP = 8'hE8;
    localparam int         TO  = 64;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0;
    logic       p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, res = 1'b0;
    logic       busy, done, pass, conflict, timeout;
    logic [7:0] table_out, mismatch;
    logic [3:0] err_cnt;

    int total = 0, bad = 0;
    int n;
    int vv[100], ix[100], rr[100], st[100];
    logic [7:0] m_tab, m_seen, m_mis;
    logic       m_conf, m_to, m_pass;
    int         m_end, m_err;

    truth_table_checker #(.EXPECTED(EXP), .TIMEOUT(TO), .TW(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
        .p1(p1), .p2(p2), .p3(p3), .res(res),
        .busy(busy), .done(done), .pass(pass), .table_out(table_out),
        .mismatch(mismatch), .err_cnt(err_cnt), .conflict(conflict), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int v, input int i, input int r, input int s);
        valid = v[0];
        {p1, p2, p3} = i[2:0];
        res = r[0];
        start = s[0];
    endtask

    // first sample per index wins; run ends on a full mask or after TO collect cycles
    task automatic model();
        m_tab = '0; m_seen = '0; m_conf = 0; m_to = 0; m_end = -1;
        for (int c = 0; m_end < 0; c++) begin
            if (c < n && vv[c] != 0) begin
                if (!m_seen[ix[c]]) begin
                    m_tab[ix[c]] = rr[c][0];
                    m_seen[ix[c]] = 1'b1;
                end else if (m_tab[ix[c]] != rr[c][0]) m_conf = 1;
            end
            if (m_seen == 8'hFF) m_end = c;
            else if (c == TO - 1) begin m_to = 1; m_end = c; end
        end
        m_mis  = (m_tab ^ EXP) & m_seen;
        m_err  = $countones(m_mis);
        m_pass = m_mis == 0 && m_seen == 8'hFF && !m_conf && !m_to;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".table"}, table_out, 0);
        check({tag, ".mis"}, mismatch, 0);
        check({tag, ".err"}, err_cnt, 0);
        check({tag, ".conf"}, conflict, 0);
        check({tag, ".to"}, timeout, 0);
    endtask

    task automatic check_result(input string tag);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".pass"}, pass, m_pass);
        check({tag, ".table"}, table_out, m_tab);
        check({tag, ".mis"}, mismatch, m_mis);
        check({tag, ".err"}, err_cnt, m_err);
        check({tag, ".conf"}, conflict, m_conf);
        check({tag, ".to"}, timeout, m_to);
    endtask

    task automatic run(input string tag);
        model();
        @(negedge clk); drive(0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0);
        check({tag, ".start_busy"}, busy, 1);
        check({tag, ".start_done"}, done, 0);
        check({tag, ".start_table"}, table_out, 0);
        check({tag, ".start_conf"}, conflict, 0);
        check({tag, ".start_to"}, timeout, 0);
        for (int c = 0; c <= m_end; c++) begin
            if (c < n) drive(vv[c], ix[c], rr[c], st[c]);
            else drive(0, 0, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        check({tag, ".cmp_busy"}, busy, 1);
        check({tag, ".cmp_done"}, done, 0);
        @(negedge clk);
        check_result(tag);
    endtask

    task automatic sweep(input logic [7:0] r);
        n = 8;
        for (int c = 0; c < 8; c++) begin vv[c] = 1; ix[c] = c; rr[c] = int'(r[c]); st[c] = 0; end
    endtask

    initial begin
        #2 check_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1, c + 5, 1, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        check_zero("idle_valid");

        sweep(EXP);
        run("sweep");
        check("sweep.table_const", table_out, 8'hE8);

        sweep(EXP ^ 8'h48);
        run("fault");
        check("fault.mis_const", mismatch, 8'h48);
        check("fault.err_const", err_cnt, 2);

        n = 9;
        vv[0] = 1; ix[0] = 5; rr[0] = 1; st[0] = 0;
        vv[1] = 1; ix[1] = 5; rr[1] = 0; st[1] = 0;
        for (int c = 0; c < 7; c++) begin
            vv[c + 2] = 1; ix[c + 2] = c < 5 ? c : c + 1; rr[c + 2] = int'(EXP[ix[c + 2]]); st[c + 2] = 0;
        end
        run("conflict");
        check("conflict.flag_const", conflict, 1);

        n = 5;
        for (int c = 0; c < 5; c++) begin vv[c] = 1; ix[c] = c; rr[c] = int'(EXP[c]); st[c] = 0; end
        rr[1] = 1;
        run("timeout");
        check("timeout.flag_const", timeout, 1);
        check("timeout.mis_const", mismatch, 8'h02);

        for (int c = 0; c < 3; c++) begin
            drive(1, c, ~int'(EXP[c]), 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        check_result("done_hold");

        sweep(EXP);
        st[2] = 1; st[6] = 1;
        run("overlap_start");

        @(negedge clk); drive(0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0);
        foreach (ix[k]) if (k < 4) begin
            drive(1, k + 4, int'(EXP[k + 4]), 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk); rst_n = 1'b1;
        sweep(EXP);
        run("after_rst");

        for (int r = 0; r < 20; r++) begin
            int lim;
            n = $urandom_range(8, 80);
            lim = ($urandom_range(0, 3) == 0) ? 6 : 7;
            for (int c = 0; c < n; c++) begin
                vv[c] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                ix[c] = $urandom_range(0, lim);
                rr[c] = int'(EXP[ix[c]]) ^ (($urandom_range(0, 9) == 0) ? 1 : 0);
                st[c] = ($urandom_range(0, 15) == 0) ? 1 : 0;
            end
            run($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Downstream consumer of the 3-input combinational stage (p1, p2, p3 -> res).
- Samples each applied input vector together with the stage's res output.
- Builds the captured 8-entry truth table and compares it against an expected table parameter.
- Reports pass/fail, mismatch locations, conflicts and timeout, so exhaustive sweeps are self-checking in simulation and on board.

Parameters:
- EXPECTED, 8'hE8, expected truth table; bit i = required res for index i = {p1,p2,p3} (p1 MSB).
- TIMEOUT, 64, max clk cycles in COLLECT before abort; must be >= 8.
- TW, 7, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new check run.
- valid  input  1  sample strobe; p1/p2/p3/res are stable and sampled this cycle.
- p1  input  1  applied input bit 2 (index MSB).
- p2  input  1  applied input bit 1.
- p3  input  1  applied input bit 0.
- res  input  1  output of the checked stage for the current vector.
- busy  output  1  high in COLLECT and COMPARE.
- done  output  1  high in DONE; held until next start.
- pass  output  1  valid when done; 1 = all 8 entries seen, no mismatch, no conflict, no timeout.
- table_out  output  8  captured res per index.
- mismatch  output  8  table_out XOR EXPECTED, masked by seen entries; valid when done.
- err_cnt  output  4  number of set bits in mismatch (0..8).
- conflict  output  1  some index was sampled twice with differing res.
- timeout  output  1  run aborted by TIMEOUT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, pass=0, table_out=0, mismatch=0, err_cnt=0, conflict=0, timeout=0. Internal seen mask and timer are cleared. Reset mid-run discards all progress.
- FSM states: IDLE, COLLECT, COMPARE, DONE.
- IDLE -> COLLECT on start. On this transition, clear table_out, seen, conflict, timeout and the timer. done drops the following cycle.
- DONE -> COLLECT on start, with the same clear. start in COLLECT or COMPARE is ignored.
- COLLECT sampling: on each valid, compute idx={p1,p2,p3}.
  - If seen[idx]=0: table_out[idx]<=res and seen[idx]<=1.
  - If seen[idx]=1 and res!=table_out[idx]: conflict<=1 (sticky for the run); table_out keeps the first value.
  - valid outside COLLECT is ignored.
- COLLECT timer: increments every cycle in COLLECT.
- COLLECT exits:
  - COLLECT -> COMPARE the cycle after seen becomes 8'hFF, including a valid that completes the mask.
  - COLLECT -> COMPARE with timeout<=1 when the timer reaches TIMEOUT-1 and seen!=8'hFF.
  - If completion and timer expiry occur in the same cycle, completion wins and timeout stays 0.
- COMPARE (exactly 1 cycle):
  - mismatch <= (table_out ^ EXPECTED) & seen.
  - err_cnt <= popcount of that value.
  - pass <= (value==0) & (seen==8'hFF) & ~conflict & ~timeout.
  - Next state DONE.
- DONE: done=1, busy=0; all result outputs held stable until next start or reset.
- Latency: done rises 2 cycles after the valid that completes the 8th distinct index (1 cycle to exit COLLECT, 1 in COMPARE).
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Exhaustive sweep with a majority-function model: start; then valid on indices 0..7 in order with res = bits of 8'hE8 -> done 2 cycles after the last valid; pass=1, table_out=8'hE8, mismatch=0, err_cnt=0.
- Fault injection: same sweep but res inverted at idx 3 and idx 6 -> pass=0, table_out=8'xA0, mismatch=8'h48, err_cnt=2.
- Duplicate/conflict: idx 5 sampled with res=1 and again with res=0, then remaining indices correct -> conflict=1, table_out[5]=1, pass=0, err_cnt=0.
- Timeout: start, then only 5 distinct indices sampled -> after 64 COLLECT cycles timeout=1, done=1, pass=0, mismatch covers only the seen bits.
- Reset mid-run: assert rst_n=0 after 4 samples -> all outputs 0 immediately (asynchronous). Release, start, full correct sweep -> pass=1.
- Out-of-window and overlap: valid pulses in IDLE and a start pulse in COLLECT -> no effect on table_out or state. A second start in DONE clears results and begins a new run.
